sha256_msg_schedule: RTL

Message-schedule generator for the SHA-256 compression datapath. It accepts one 512-bit message block as sixteen 32-bit words over a valid/ready input, then streams the 64 schedule words W[0..63], each paired with its round constant K[t], over a valid/ready output. It is the producer that feeds the `w_t`/`k_t` inputs of the per-round combinational logic, one round per accepted output beat.

---
 rtl/sha256_msg_schedule_if.sv | 23 ++
 rtl/sha256_msg_schedule.sv | 120 ++++++++++++
 2 files changed

// File: rtl/sha256_msg_schedule_if.sv
// Handshake bundle between a message-word source, the schedule generator
// and the downstream round stage.
interface sha256_msg_schedule_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_word;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] w_t;
  logic [31:0] k_t;
  logic [5:0]  t_idx;
  logic        out_last;

  modport master (
    output in_valid, in_word, out_ready,
    input  in_ready, out_valid, w_t, k_t, t_idx, out_last
  );

  modport slave (
    input  in_valid, in_word, out_ready,
    output in_ready, out_valid, w_t, k_t, t_idx, out_last
  );
endinterface

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads sixteen message words, then streams
// W[0..63] with the matching round constant K[t] from a 16-word sliding window.
module sha256_msg_schedule (
  input  logic                        clk,
  input  logic                        rst,
  sha256_msg_schedule_if.slave        bus
);

  typedef enum logic {LOAD = 1'b0, RUN = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] win [16];
  logic [3:0]  lcnt;
  logic [5:0]  t;
  logic        load_fire;
  logic        run_fire;
  logic [31:0] w_new;

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  function automatic logic [31:0] k_lookup(input logic [5:0] i);
    logic [31:0] k;
    k = 32'h0;
    case (i)
      6'd0:  k = 32'h428a2f98;  6'd1:  k = 32'h71374491;
      6'd2:  k = 32'hb5c0fbcf;  6'd3:  k = 32'he9b5dba5;
      6'd4:  k = 32'h3956c25b;  6'd5:  k = 32'h59f111f1;
      6'd6:  k = 32'h923f82a4;  6'd7:  k = 32'hab1c5ed5;
      6'd8:  k = 32'hd807aa98;  6'd9:  k = 32'h12835b01;
      6'd10: k = 32'h243185be;  6'd11: k = 32'h550c7dc3;
      6'd12: k = 32'h72be5d74;  6'd13: k = 32'h80deb1fe;
      6'd14: k = 32'h9bdc06a7;  6'd15: k = 32'hc19bf174;
      6'd16: k = 32'he49b69c1;  6'd17: k = 32'hefbe4786;
      6'd18: k = 32'h0fc19dc6;  6'd19: k = 32'h240ca1cc;
      6'd20: k = 32'h2de92c6f;  6'd21: k = 32'h4a7484aa;
      6'd22: k = 32'h5cb0a9dc;  6'd23: k = 32'h76f988da;
      6'd24: k = 32'h983e5152;  6'd25: k = 32'ha831c66d;
      6'd26: k = 32'hb00327c8;  6'd27: k = 32'hbf597fc7;
      6'd28: k = 32'hc6e00bf3;  6'd29: k = 32'hd5a79147;
      6'd30: k = 32'h06ca6351;  6'd31: k = 32'h14292967;
      6'd32: k = 32'h27b70a85;  6'd33: k = 32'h2e1b2138;
      6'd34: k = 32'h4d2c6dfc;  6'd35: k = 32'h53380d13;
      6'd36: k = 32'h650a7354;  6'd37: k = 32'h766a0abb;
      6'd38: k = 32'h81c2c92e;  6'd39: k = 32'h92722c85;
      6'd40: k = 32'ha2bfe8a1;  6'd41: k = 32'ha81a664b;
      6'd42: k = 32'hc24b8b70;  6'd43: k = 32'hc76c51a3;
      6'd44: k = 32'hd192e819;  6'd45: k = 32'hd6990624;
      6'd46: k = 32'hf40e3585;  6'd47: k = 32'h106aa070;
      6'd48: k = 32'h19a4c116;  6'd49: k = 32'h1e376c08;
      6'd50: k = 32'h2748774c;  6'd51: k = 32'h34b0bcb5;
      6'd52: k = 32'h391c0cb3;  6'd53: k = 32'h4ed8aa4a;
      6'd54: k = 32'h5b9cca4f;  6'd55: k = 32'h682e6ff3;
      6'd56: k = 32'h748f82ee;  6'd57: k = 32'h78a5636f;
      6'd58: k = 32'h84c87814;  6'd59: k = 32'h8cc70208;
      6'd60: k = 32'h90befffa;  6'd61: k = 32'ha4506ceb;
      6'd62: k = 32'hbef9a3f7;  6'd63: k = 32'hc67178f2;
      default: k = 32'h0;
    endcase
    return k;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state_q <= LOAD;
    else     state_q <= state_d;
  end

  // Handshake decode: ready/valid depend only on the state register.
  always_comb begin
    state_d       = state_q;
    load_fire     = 1'b0;
    run_fire      = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state_q)
      LOAD: begin
        bus.in_ready = 1'b1;
        load_fire    = bus.in_valid;
        if (load_fire && lcnt == 4'd15) state_d = RUN;
      end
      RUN: begin
        bus.out_valid = 1'b1;
        run_fire      = bus.out_ready;
        if (run_fire && t == 6'd63) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  // W[t+16] from the window; past t=47 the result is shifted in but never emitted.
  assign w_new = sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      lcnt <= 4'd0;
      t    <= 6'd0;
      for (int i = 0; i < 16; i++) win[i] <= 32'h0;
    end else if (load_fire) begin
      for (int i = 0; i < 15; i++) win[i] <= win[i+1];
      win[15] <= bus.in_word;
      lcnt    <= lcnt + 4'd1;
      t       <= 6'd0;
    end else if (run_fire) begin
      for (int i = 0; i < 15; i++) win[i] <= win[i+1];
      win[15] <= w_new;
      t       <= t + 6'd1;
    end
  end

  assign bus.w_t      = win[0];
  assign bus.k_t      = k_lookup(t);
  assign bus.t_idx    = t;
  assign bus.out_last = (state_q == RUN) && (t == 6'd63);

endmodule
